// File: rtl/instr_fetch.sv
// instr_fetch: single-stage instruction fetch with stall, redirect and optional halt-on-zero (FETCH_HALT_EN)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);
  logic [31:0] pc_q, pc_d, instr_d, ipc_d;
  logic        valid_d, slot_free, run, halt_word;
  assign imem_addr = pc_q[9:2];
  assign slot_free = !if_valid || id_ready;
`ifdef FETCH_HALT_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  assign run       = state == RUN;
  assign halted    = state == HALT;
  assign halt_word = imem_data == 32'h0;
  // state register; a zero word parks fetch until redirect or reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_d;
  // next state: redirect always resumes, a zero word captured in RUN halts
  always_comb begin
    state_d = state;
    if (redirect_valid) state_d = RUN;
    else if (run && slot_free && halt_word) state_d = HALT;
  end
`else
  assign run       = 1'b1;
  assign halted    = 1'b0;
  assign halt_word = 1'b0;
`endif
  // next fetch/output values: redirect beats stall, halt and sequential fetch
  always_comb begin
    pc_d    = pc_q;
    valid_d = if_valid;
    instr_d = if_instr;
    ipc_d   = if_pc;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h3;
      valid_d = 1'b0;
    end else if (slot_free) begin
      valid_d = 1'b0;
      if (run && !halt_word) begin
        valid_d = 1'b1;
        instr_d = imem_data;
        ipc_d   = pc_q;
        pc_d    = pc_q + 32'd4;
      end
    end
  end
  // pc and output slot registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      if_valid <= valid_d;
      if_instr <= instr_d;
      if_pc    <= ipc_d;
    end
  // delivered-instruction counter, saturating; counts even when a redirect lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_count <= 16'h0;
    else if (if_valid && id_ready && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
endmodule
